// File: rtl/pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mux_n
// Description : N:1 operand-select mux with registered output, main + skid
//               buffer for lossless back-pressure, flush and bad-select flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mux_n #(
    parameter int              WIDTH       = 32,
    parameter int              NUM_IN      = 4,
    parameter int              SEL_W       = 2,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stateEnum;

    stateEnum         r_state;
    stateEnum         w_nextState;

    logic [WIDTH-1:0] r_mainData;
    logic [SEL_W-1:0] r_mainSel;
    logic             r_mainErr;
    logic [WIDTH-1:0] r_skidData;
    logic [SEL_W-1:0] r_skidSel;
    logic             r_skidErr;

    logic [WIDTH-1:0] w_inArr [NUM_IN];
    logic [WIDTH-1:0] w_capData;
    logic             w_capErr;
    logic             w_accept;
    logic             w_pop;
    logic             w_loadMainIn;
    logic             w_loadMainSkid;
    logic             w_loadSkid;

    genvar k;
    generate
        for (k = 0; k < NUM_IN; k++) begin : g_unpack
            assign w_inArr[k] = in_bus[k*WIDTH +: WIDTH];
        end
    endgenerate

    // A select that matches no input yields DEFAULT_VAL and raises err.
    always_comb begin
        w_capData = DEFAULT_VAL;
        w_capErr  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                w_capData = w_inArr[i];
                w_capErr  = 1'b0;
            end
        end
    end

    assign in_ready  = (r_state != ST_FULL);
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_mainData;
    assign out_sel   = r_mainSel;
    assign out_err   = r_mainErr;

    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready;

    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        if (flush) begin
            w_nextState = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_nextState  = ST_ONE;
                        w_loadMainIn = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_loadMainIn = 1'b1;
                    end else if (w_accept) begin
                        w_nextState = ST_FULL;
                        w_loadSkid  = 1'b1;
                    end else if (w_pop) begin
                        w_nextState = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_nextState    = ST_ONE;
                        w_loadMainSkid = 1'b1;
                    end
                end
                default: w_nextState = ST_EMPTY;
            endcase
        end
    end

    // Output payload registers are left untouched on flush so the last value holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_mainData <= '0;
            r_mainSel  <= '0;
            r_mainErr  <= 1'b0;
            r_skidData <= '0;
            r_skidSel  <= '0;
            r_skidErr  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_loadMainIn) begin
                r_mainData <= w_capData;
                r_mainSel  <= sel;
                r_mainErr  <= w_capErr;
            end else if (w_loadMainSkid) begin
                r_mainData <= r_skidData;
                r_mainSel  <= r_skidSel;
                r_mainErr  <= r_skidErr;
            end
            if (w_loadSkid) begin
                r_skidData <= w_capData;
                r_skidSel  <= sel;
                r_skidErr  <= w_capErr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_mux_n
// Description : Directed self-checking bench for pipe_mux_n (4:1 and 3:1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_mux_n;

    logic         clk;
    logic         reset;

    logic [127:0] aBus;
    logic [1:0]   aSel;
    logic         aInValid;
    logic         aInReady;
    logic         aFlush;
    logic [31:0]  aOutData;
    logic [1:0]   aOutSel;
    logic         aOutErr;
    logic         aOutValid;
    logic         aOutReady;

    logic [47:0]  bBus;
    logic [1:0]   bSel;
    logic         bInValid;
    logic         bInReady;
    logic         bFlush;
    logic [15:0]  bOutData;
    logic [1:0]   bOutSel;
    logic         bOutErr;
    logic         bOutValid;
    logic         bOutReady;

    int checks;
    int errors;

    pipe_mux_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VAL(32'h0)) dutA (
        .clk(clk), .reset(reset), .in_bus(aBus), .sel(aSel),
        .in_valid(aInValid), .in_ready(aInReady), .flush(aFlush),
        .out_data(aOutData), .out_sel(aOutSel), .out_err(aOutErr),
        .out_valid(aOutValid), .out_ready(aOutReady)
    );

    pipe_mux_n #(.WIDTH(16), .NUM_IN(3), .SEL_W(2), .DEFAULT_VAL(16'hDEAD)) dutB (
        .clk(clk), .reset(reset), .in_bus(bBus), .sel(bSel),
        .in_valid(bInValid), .in_ready(bInReady), .flush(bFlush),
        .out_data(bOutData), .out_sel(bOutSel), .out_err(bOutErr),
        .out_valid(bOutValid), .out_ready(bOutReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        aBus      = {32'h44, 32'h33, 32'h22, 32'h11};
        aSel      = 2'd0;
        aInValid  = 1'b0;
        aFlush    = 1'b0;
        aOutReady = 1'b0;
        bBus      = {16'h0333, 16'h0222, 16'h0111};
        bSel      = 2'd0;
        bInValid  = 1'b0;
        bFlush    = 1'b0;
        bOutReady = 1'b0;

        // reset for three cycles
        step(); step(); step();
        chk("rst_valid", 32'(aOutValid), 32'd0);
        chk("rst_data",  aOutData,        32'd0);
        chk("rst_sel",   32'(aOutSel),    32'd0);
        chk("rst_err",   32'(aOutErr),    32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(aInReady),  32'd1);
        chk("post_rst_valid", 32'(aOutValid), 32'd0);

        // single transfer, sel=2
        aSel = 2'd2; aInValid = 1'b1; aOutReady = 1'b1;
        step();
        chk("t2_data",  aOutData,         32'h33);
        chk("t2_sel",   32'(aOutSel),     32'd2);
        chk("t2_valid", 32'(aOutValid),   32'd1);
        chk("t2_err",   32'(aOutErr),     32'd0);
        aInValid = 1'b0;
        step();
        chk("t2_drain_valid", 32'(aOutValid), 32'd0);
        chk("t2_drain_hold",  aOutData,       32'h33);

        // back-pressure fills main then skid
        aOutReady = 1'b0; aInValid = 1'b1; aSel = 2'd0;
        step();
        chk("t3_one_data",  aOutData,       32'h11);
        chk("t3_one_ready", 32'(aInReady),  32'd1);
        aSel = 2'd1;
        step();
        chk("t3_full_ready", 32'(aInReady), 32'd0);
        chk("t3_full_hold",  aOutData,      32'h11);
        aSel = 2'd3; aBus = {4{32'hBAD0BAD0}};
        step();
        chk("t3_stall_data", aOutData,      32'h11);
        chk("t3_stall_sel",  32'(aOutSel),  32'd0);
        aInValid = 1'b0; aOutReady = 1'b1;
        aBus = {32'h44, 32'h33, 32'h22, 32'h11};
        step();
        chk("t3_pop_skid_data",  aOutData,       32'h22);
        chk("t3_pop_skid_sel",   32'(aOutSel),   32'd1);
        chk("t3_pop_skid_ready", 32'(aInReady),  32'd1);
        step();
        chk("t3_empty", 32'(aOutValid), 32'd0);

        // streaming: accept and pop in the same cycle
        aInValid = 1'b1; aSel = 2'd3;
        step();
        chk("stream_a", aOutData, 32'h44);
        aSel = 2'd0;
        step();
        chk("stream_b",       aOutData,       32'h11);
        chk("stream_b_valid", 32'(aOutValid), 32'd1);
        aInValid = 1'b0;
        step();
        chk("stream_empty", 32'(aOutValid), 32'd0);

        // out-of-range select on the 3-input instance
        bSel = 2'd3; bInValid = 1'b1; bOutReady = 1'b1;
        step();
        chk("t4_default_data", 32'(bOutData),  32'hDEAD);
        chk("t4_err",          32'(bOutErr),   32'd1);
        chk("t4_sel",          32'(bOutSel),   32'd3);
        bSel = 2'd2;
        step();
        chk("t4_in_range_data", 32'(bOutData), 32'h0333);
        chk("t4_in_range_err",  32'(bOutErr),  32'd0);
        bInValid = 1'b0;
        step();
        chk("t4_empty", 32'(bOutValid), 32'd0);

        // flush while FULL with a concurrent offer
        aOutReady = 1'b0; aInValid = 1'b1; aSel = 2'd2;
        step();
        aSel = 2'd3;
        step();
        chk("t5_full", 32'(aInReady), 32'd0);
        aFlush = 1'b1; aSel = 2'd1;
        step();
        chk("t5_valid", 32'(aOutValid), 32'd0);
        chk("t5_ready", 32'(aInReady),  32'd1);
        chk("t5_hold",  aOutData,       32'h33);
        aFlush = 1'b0; aInValid = 1'b0; aOutReady = 1'b1;
        step();
        chk("t5_dropped_1", 32'(aOutValid), 32'd0);
        step();
        chk("t5_dropped_2", 32'(aOutValid), 32'd0);

        // flush from EMPTY drops the offered entry
        aFlush = 1'b1; aInValid = 1'b1; aSel = 2'd0;
        step();
        chk("flush_empty_valid", 32'(aOutValid), 32'd0);
        aFlush = 1'b0; aInValid = 1'b0;

        // reset while FULL
        aOutReady = 1'b0; aInValid = 1'b1; aSel = 2'd0;
        step();
        aSel = 2'd1;
        step();
        chk("t6_full", 32'(aInReady), 32'd0);
        aInValid = 1'b0; reset = 1'b1;
        step();
        chk("t6_valid", 32'(aOutValid), 32'd0);
        chk("t6_data",  aOutData,       32'd0);
        chk("t6_ready", 32'(aInReady),  32'd1);
        reset = 1'b0; aOutReady = 1'b1;
        step();
        chk("t6_no_partial", 32'(aOutValid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
